// File: rtl/rom_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_controller_pkg
//  Description : Shared types and constants for the ROM-read responder:
//                FSM state encoding, byte-beat selectors and the width of
//                the per-byte wait counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_controller_pkg;

  // The wait counter must hold WAIT_CYCLES-1 for the full legal range 1..15.
  localparam int CNT_W = 4;

  // Low bit of the flash byte address selects the beat (little-endian).
  localparam logic BYTE_LO = 1'b0;
  localparam logic BYTE_HI = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : rom_controller_pkg
`default_nettype wire

// File: rtl/rom_controller_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_controller_wait_counter
//  Description : Loadable down-counter with a zero flag. Times how long the
//                flash output enable is held before a byte is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_controller_wait_counter
  import rom_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load has priority; decrement never goes below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule : rom_controller_wait_counter
`default_nettype wire

// File: rtl/rom_controller.sv
`default_nettype none
// ============================================================================
//  Module      : rom_controller
//  Description : Word-read responder for the DMA engine. Each request is
//                served as two byte reads from an 8-bit parallel flash,
//                low byte first, and returned as one 16-bit word with a
//                single-cycle ready strobe. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_controller
  import rom_controller_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ROM_ADDR    = 23,
  parameter int WAIT_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_rom,
  input  logic [ROM_ADDR-1:0] src_addr,
  output logic [WIDTH-1:0]    src_data,
  output logic                ready,
  output logic                busy,
  output logic                overrun,
  output logic [ROM_ADDR:0]   flash_addr,
  input  logic [7:0]          flash_data_in,
  output logic                flash_ce_n,
  output logic                flash_oe_n,
  output logic                flash_we_n
);

  localparam logic [CNT_W-1:0] C_WAIT_RELOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [ROM_ADDR-1:0] addr_q, addr_d;
  logic [7:0]          lo_byte_q, lo_byte_d;
  logic [WIDTH-1:0]    src_data_q, src_data_d;
  logic                overrun_q, overrun_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic [ROM_ADDR:0]   flash_addr_q, flash_addr_d;

  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  rom_controller_wait_counter u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (C_WAIT_RELOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state, byte assembly and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    lo_byte_d    = lo_byte_q;
    src_data_d   = src_data_q;
    overrun_d    = overrun_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    flash_addr_d = flash_addr_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts a new request directly so back-to-back reads skip IDLE.
        if (load_rom) begin
          addr_d   = src_addr;
          cnt_load = 1'b1;
          state_d  = ST_LO;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_LO: begin
        overrun_d = overrun_q | load_rom;
        if (cnt_zero) begin
          lo_byte_d = flash_data_in;
          cnt_load  = 1'b1;
          state_d   = ST_HI;
        end else begin
          cnt_dec   = 1'b1;
        end
      end
      ST_HI: begin
        overrun_d = overrun_q | load_rom;
        if (cnt_zero) begin
          src_data_d = {flash_data_in, lo_byte_q};
          state_d    = ST_DONE;
        end else begin
          cnt_dec    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are derived from the next state so they appear registered
    // in the same cycle the state takes effect.
    busy_d  = (state_d == ST_LO) || (state_d == ST_HI);
    ce_n_d  = !busy_d;
    oe_n_d  = !busy_d;
    ready_d = (state_d == ST_DONE);
    if (state_d == ST_LO) begin
      flash_addr_d = {addr_d, BYTE_LO};
    end else if (state_d == ST_HI) begin
      flash_addr_d = {addr_d, BYTE_HI};
    end
  end

  // State and output registers; reset drops the flash pins immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      lo_byte_q    <= '0;
      src_data_q   <= '0;
      overrun_q    <= 1'b0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      flash_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      lo_byte_q    <= lo_byte_d;
      src_data_q   <= src_data_d;
      overrun_q    <= overrun_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      flash_addr_q <= flash_addr_d;
    end
  end

  assign src_data   = src_data_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign flash_addr = flash_addr_q;
  assign flash_ce_n = ce_n_q;
  assign flash_oe_n = oe_n_q;
  assign flash_we_n = 1'b1;

endmodule : rom_controller
`default_nettype wire

// File: tb/tb_rom_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_controller
//  Description : Self-checking bench for rom_controller. A transaction-level
//                model predicts every cycle of the default instance; a
//                second instance with WAIT_CYCLES=1 covers address wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_controller;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance
  logic        load_rom;
  logic [22:0] src_addr;
  logic [15:0] src_data;
  logic        ready, busy, overrun;
  logic [23:0] flash_addr;
  logic [7:0]  flash_data_in;
  logic        flash_ce_n, flash_oe_n, flash_we_n;

  // WAIT_CYCLES=1 instance
  logic        load1;
  logic [22:0] addr1;
  logic [15:0] data1;
  logic        ready1, busy1, ovr1;
  logic [23:0] faddr1;
  logic [7:0]  fdata1;
  logic        ce1, oe1, we1;

  int n_cmp = 0;
  int n_bad = 0;

  // Flash contents: two fixed bytes, everything else derived from address.
  function automatic logic [7:0] rom_byte(input logic [23:0] a);
    if (a == 24'h000010) return 8'h0A;
    if (a == 24'h000011) return 8'hB0;
    return a[7:0] ^ 8'h3C;
  endfunction

  assign flash_data_in = rom_byte(flash_addr);
  assign fdata1        = rom_byte(faddr1);

  rom_controller #(.WIDTH(16), .ROM_ADDR(23), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .load_rom(load_rom), .src_addr(src_addr),
    .src_data(src_data), .ready(ready), .busy(busy), .overrun(overrun),
    .flash_addr(flash_addr), .flash_data_in(flash_data_in),
    .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n)
  );

  rom_controller #(.WIDTH(16), .ROM_ADDR(23), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .load_rom(load1), .src_addr(addr1),
    .src_data(data1), .ready(ready1), .busy(busy1), .overrun(ovr1),
    .flash_addr(faddr1), .flash_data_in(fdata1),
    .flash_ce_n(ce1), .flash_oe_n(oe1), .flash_we_n(we1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a read accepted at cycle s drives byte 2a during
  // cycles s+1..s+W, byte 2a+1 during s+W+1..s+2W, completes at s+2W+1.
  bit          m_act = 1'b0;
  int          m_start = 0;
  logic [22:0] m_addr = '0;
  logic [15:0] m_data = '0;
  bit          m_ovr = 1'b0;
  int          cyc = 0;
  int          ph;
  bit          e_busy, e_rdy;

  // Per-cycle comparison against the model, then advance it with the
  // inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_act  = 1'b0;
      m_data = '0;
      m_ovr  = 1'b0;
    end else begin
      ph     = cyc - m_start;
      e_busy = m_act && (ph >= 1) && (ph <= 2 * W);
      e_rdy  = m_act && (ph == 2 * W + 1);
      if (e_rdy) m_data = {rom_byte({m_addr, 1'b1}), rom_byte({m_addr, 1'b0})};
      chk("busy",     32'(busy),       32'(e_busy));
      chk("ready",    32'(ready),      32'(e_rdy));
      chk("ce_n",     32'(flash_ce_n), 32'(!e_busy));
      chk("oe_n",     32'(flash_oe_n), 32'(!e_busy));
      chk("we_n",     32'(flash_we_n), 32'd1);
      chk("overrun",  32'(overrun),    32'(m_ovr));
      chk("src_data", 32'(src_data),   32'(m_data));
      if (e_busy) chk("flash_addr", 32'(flash_addr), 32'({m_addr, (ph > W)}));
      if (load_rom) begin
        if (!m_act || e_rdy) begin
          m_act   = 1'b1;
          m_start = cyc;
          m_addr  = src_addr;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (e_rdy) begin
        m_act = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    load_rom = 1'b0; src_addr = '0; load1 = 1'b0; addr1 = '0;
    tick(3);
    rst = 1'b0;
    tick(10);
    chk("idle ready",    32'(ready),      32'd0);
    chk("idle busy",     32'(busy),       32'd0);
    chk("idle ce_n",     32'(flash_ce_n), 32'd1);
    chk("idle oe_n",     32'(flash_oe_n), 32'd1);
    chk("idle we_n",     32'(flash_we_n), 32'd1);
    chk("idle src_data", 32'(src_data),   32'd0);

    // Single read of word 8: bytes 0x0A @0x10, 0xB0 @0x11.
    load_rom = 1'b1; src_addr = 23'h000008;
    tick(1);
    load_rom = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("rd0 flash_addr", 32'(flash_addr), (c <= 4) ? 32'h10 : 32'h11);
      tick(1);
    end
    chk("rd0 ready", 32'(ready),    32'd1);
    chk("rd0 data",  32'(src_data), 32'hB00A);

    // Back-to-back request in the DONE cycle: word 9 -> 0x2F2E.
    load_rom = 1'b1; src_addr = 23'h000009;
    tick(1);
    load_rom = 1'b0;
    chk("b2b flash_addr", 32'(flash_addr), 32'h12);
    chk("b2b busy",       32'(busy),       32'd1);
    tick(8);
    chk("b2b ready", 32'(ready),    32'd1);
    chk("b2b data",  32'(src_data), 32'h2F2E);
    tick(3);

    // Request during HI: flagged, ignored; word 0x20 -> 0x7D7C.
    load_rom = 1'b1; src_addr = 23'h000020;
    tick(1);
    load_rom = 1'b0;
    tick(5);
    load_rom = 1'b1; src_addr = 23'h000030;
    tick(1);
    load_rom = 1'b0;
    chk("ovr set", 32'(overrun), 32'd1);
    tick(2);
    chk("ovr ready", 32'(ready),    32'd1);
    chk("ovr data",  32'(src_data), 32'h7D7C);
    tick(1);
    chk("ovr no extra busy", 32'(busy), 32'd0);
    tick(4);
    chk("ovr sticky", 32'(overrun), 32'd1);

    // Reset in LO: pins released at once, no ready.
    load_rom = 1'b1; src_addr = 23'h000040;
    tick(1);
    load_rom = 1'b0;
    tick(1);
    rst = 1'b1;
    #1;
    chk("rst ce_n",    32'(flash_ce_n), 32'd1);
    chk("rst oe_n",    32'(flash_oe_n), 32'd1);
    chk("rst data",    32'(src_data),   32'd0);
    chk("rst overrun", 32'(overrun),    32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
    load_rom = 1'b1; src_addr = 23'h000041;
    tick(1);
    load_rom = 1'b0;
    tick(8);
    chk("post-rst ready", 32'(ready),    32'd1);
    chk("post-rst data",  32'(src_data), 32'hBFBE);
    tick(3);

    // WAIT_CYCLES=1 at the top of the address space.
    load1 = 1'b1; addr1 = 23'h7FFFFF;
    tick(1);
    load1 = 1'b0;
    chk("w1 addr lo", 32'(faddr1), 32'hFFFFFE);
    chk("w1 ready c1", 32'(ready1), 32'd0);
    tick(1);
    chk("w1 addr hi", 32'(faddr1), 32'hFFFFFF);
    tick(1);
    chk("w1 ready", 32'(ready1), 32'd1);
    chk("w1 data",  32'(data1),  32'hC3C2);
    tick(1);
    chk("w1 ready drop", 32'(ready1), 32'd0);
    chk("w1 ce_n",       32'(ce1),    32'd1);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rom_controller
`default_nettype wire
